// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and helpers for the fifo_umbral FIFO and its bench.
//   DEFAULT_DATA_WIDTH    : default word width in bits
//   DEFAULT_ADDRESS_WIDTH : default pointer width in bits
//   depth(aw)             : number of words addressed by an aw-bit pointer
//   count_width(aw)       : width able to hold an occupancy of 0..depth(aw)
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 10;
  localparam int DEFAULT_ADDRESS_WIDTH = 8;

  function automatic int depth(input int address_width);
    return 1 << address_width;
  endfunction

  // One extra bit so that a completely full FIFO (count == depth) is representable.
  function automatic int count_width(input int address_width);
    return address_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p
// Simple dual-port register-file memory with a synchronous write port and a
// registered read port. The storage array is never reset; only the read data
// register is cleared so the FIFO output starts at zero.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high, clears rdata only
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable, rdata loads mem[raddr] at the edge
//   raddr  : read address
//   rdata  : registered read data, holds its value when re is low
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int data_width    = DEFAULT_DATA_WIDTH,
  parameter int address_width = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [address_width-1:0] waddr,
  input  logic [data_width-1:0]    wdata,
  input  logic                     re,
  input  logic [address_width-1:0] raddr,
  output logic [data_width-1:0]    rdata
);

  logic [data_width-1:0] mem [depth(address_width)];

  // Array has no reset so it maps onto plain register-file storage.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is read-before-write; the FIFO control never reads and writes the
  // same live entry in one cycle, so the ordering never matters in practice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_umbral.sv
// fifo_umbral
// Single-clock synchronous FIFO with run-time programmable almost-full and
// almost-empty thresholds, occupancy count, registered read-valid strobe and a
// sticky, clearable overflow/underflow error.
// Ports:
//   clk               : clock, rising edge
//   reset             : asynchronous active-high, clears pointers/count/outputs
//   wr_enable         : write request, accepted unless full
//   rd_enable         : read request, accepted unless empty
//   data_in           : write data
//   umbral_lleno      : almost-full threshold (count >= umbral_lleno)
//   umbral_vacio      : almost-empty threshold (count <= umbral_vacio)
//   err_clear         : synchronous clear of the sticky error
//   data_out          : read data, one cycle after an accepted read
//   valid_out         : data_out holds a freshly read word this cycle
//   full_fifo         : count == DEPTH
//   empty_fifo        : count == 0
//   almost_full_fifo  : count >= umbral_lleno
//   almost_empty_fifo : count <= umbral_vacio
//   count             : occupancy 0..DEPTH
//   error             : sticky, a request was rejected
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter  int data_width    = DEFAULT_DATA_WIDTH,
  parameter  int address_width = DEFAULT_ADDRESS_WIDTH,
  localparam int count_width   = fifo_pkg::count_width(address_width)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_enable,
  input  logic                   rd_enable,
  input  logic [data_width-1:0]  data_in,
  input  logic [count_width-1:0] umbral_lleno,
  input  logic [count_width-1:0] umbral_vacio,
  input  logic                   err_clear,
  output logic [data_width-1:0]  data_out,
  output logic                   valid_out,
  output logic                   full_fifo,
  output logic                   empty_fifo,
  output logic                   almost_full_fifo,
  output logic                   almost_empty_fifo,
  output logic [count_width-1:0] count,
  output logic                   error
);

  localparam logic [count_width-1:0] DEPTH_COUNT = count_width'(depth(address_width));

  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic                     wr_acc;
  logic                     rd_acc;

  // Flags come straight from the registered count so they move with it;
  // thresholds above DEPTH naturally pin almost_full low and almost_empty high.
  always_comb begin
    full_fifo         = (count == DEPTH_COUNT);
    empty_fifo        = (count == '0);
    almost_full_fifo  = (count >= umbral_lleno);
    almost_empty_fifo = (count <= umbral_vacio);
    wr_acc            = wr_enable & ~full_fifo;
    rd_acc            = rd_enable & ~empty_fifo;
  end

  // Pointers wrap naturally at address_width bits. A simultaneous write and
  // read on an empty FIFO only takes the write: no bypass path to data_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      valid_out <= rd_acc;
      // Setting beats clearing when both happen in the same cycle.
      if ((wr_enable & full_fifo) | (rd_enable & empty_fifo)) begin
        error <= 1'b1;
      end else if (err_clear) begin
        error <= 1'b0;
      end
    end
  end

  fifo_mem_2p #(
    .data_width   (data_width),
    .address_width(address_width)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re   (rd_acc),
    .raddr(rd_ptr),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral
// Bench for fifo_umbral with data_width=10, address_width=2 (DEPTH=4).
// A queue-based reference model tracks what the FIFO must hold and a compare
// process checks every DUT output shortly after each rising edge; directed
// sequences also check hand-computed literal values.
module tb_fifo_umbral;
  import fifo_pkg::*;

  localparam int DW    = 10;
  localparam int AW    = 2;
  localparam int CW    = fifo_pkg::count_width(AW);
  localparam int DEPTH = fifo_pkg::depth(AW);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_enable = 1'b0;
  logic          rd_enable = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] umbral_lleno = CW'(3);
  logic [CW-1:0] umbral_vacio = CW'(1);
  logic          err_clear = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full_fifo;
  logic          empty_fifo;
  logic          almost_full_fifo;
  logic          almost_empty_fifo;
  logic [CW-1:0] count;
  logic          error;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  fifo_umbral #(
    .data_width   (DW),
    .address_width(AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_enable        (wr_enable),
    .rd_enable        (rd_enable),
    .data_in          (data_in),
    .umbral_lleno     (umbral_lleno),
    .umbral_vacio     (umbral_vacio),
    .err_clear        (err_clear),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .full_fifo        (full_fifo),
    .empty_fifo       (empty_fifo),
    .almost_full_fifo (almost_full_fifo),
    .almost_empty_fifo(almost_empty_fifo),
    .count            (count),
    .error            (error)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, outputs derived from its size.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_valid = 1'b0;
  logic          m_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      automatic bit was_full  = (m_q.size() == DEPTH);
      automatic bit was_empty = (m_q.size() == 0);
      automatic bit wacc      = wr_enable && !was_full;
      automatic bit racc      = rd_enable && !was_empty;
      if (racc) begin
        m_dout = m_q.pop_front();
      end
      m_valid = racc;
      if (wacc) begin
        m_q.push_back(data_in);
      end
      if ((wr_enable && was_full) || (rd_enable && was_empty)) begin
        m_err = 1'b1;
      end else if (err_clear) begin
        m_err = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every cycle, just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      automatic int n = m_q.size();
      checkOutput("model count", int'(count), n);
      checkOutput("model empty", int'(empty_fifo), int'(n == 0));
      checkOutput("model full", int'(full_fifo), int'(n == DEPTH));
      checkOutput("model almost_full", int'(almost_full_fifo), int'(n >= int'(umbral_lleno)));
      checkOutput("model almost_empty", int'(almost_empty_fifo), int'(n <= int'(umbral_vacio)));
      checkOutput("model valid_out", int'(valid_out), int'(m_valid));
      checkOutput("model data_out", int'(data_out), int'(m_dout));
      checkOutput("model error", int'(error), int'(m_err));
    end
  end

  // Called at a falling edge: drives inputs, then waits for the next falling
  // edge so the caller sees the result of the intervening rising edge.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [DW-1:0] din, input bit clr);
    wr_enable = wr;
    rd_enable = rd;
    data_in   = din;
    err_clear = clr;
    @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 0);
    checkOutput("idle empty", int'(empty_fifo), 1);
    checkOutput("idle full", int'(full_fifo), 0);
    checkOutput("idle almost_empty", int'(almost_empty_fifo), 1);
    checkOutput("idle almost_full", int'(almost_full_fifo), 0);
    checkOutput("idle count", int'(count), 0);
    checkOutput("idle error", int'(error), 0);
    checkOutput("idle valid", int'(valid_out), 0);

    // Fill with 0x001..0x004.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 0, DW'(i), 0);
      checkOutput("fill count", int'(count), i);
      checkOutput("fill almost_empty", int'(almost_empty_fifo), int'(i <= 1));
      checkOutput("fill almost_full", int'(almost_full_fifo), int'(i >= 3));
      checkOutput("fill full", int'(full_fifo), int'(i == 4));
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, '0, 0);
      checkOutput("drain data", int'(data_out), i);
      checkOutput("drain valid", int'(valid_out), 1);
    end
    checkOutput("drain empty", int'(empty_fifo), 1);
    applyStimulus(0, 0, '0, 0);
    checkOutput("drain idle valid", int'(valid_out), 0);
    checkOutput("drain hold data", int'(data_out), 4);

    // Overflow: rejected write, sticky error, then clear.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, DW'(16 + i), 0);
    applyStimulus(1, 0, 10'h3FF, 0);
    checkOutput("overflow error", int'(error), 1);
    checkOutput("overflow count", int'(count), 4);
    applyStimulus(0, 0, '0, 1);
    checkOutput("err_clear error", int'(error), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, '0, 0);
      checkOutput("overflow readback", int'(data_out), 16 + i);
    end

    // Streaming with two words stored; pointers wrap past 3.
    applyStimulus(1, 0, 10'h020, 0);
    applyStimulus(1, 0, 10'h021, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1, DW'(32 + 2 + k), 0);
      checkOutput("stream count", int'(count), 2);
      checkOutput("stream data", int'(data_out), 32 + k);
      checkOutput("stream valid", int'(valid_out), 1);
    end
    applyStimulus(0, 1, '0, 0);
    checkOutput("stream tail0", int'(data_out), 10'h026);
    applyStimulus(0, 1, '0, 0);
    checkOutput("stream tail1", int'(data_out), 10'h027);

    // Simultaneous write and read on empty: write only, underflow flagged.
    applyStimulus(1, 1, 10'h155, 0);
    checkOutput("empty wr+rd count", int'(count), 1);
    checkOutput("empty wr+rd valid", int'(valid_out), 0);
    checkOutput("empty wr+rd error", int'(error), 1);
    applyStimulus(0, 1, '0, 1);
    checkOutput("no-bypass data", int'(data_out), 10'h155);
    checkOutput("no-bypass valid", int'(valid_out), 1);
    checkOutput("no-bypass error cleared", int'(error), 0);

    // Thresholds above DEPTH.
    umbral_lleno = CW'(5);
    umbral_vacio = CW'(6);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, DW'(64 + i), 0);
    checkOutput("high thr almost_full", int'(almost_full_fifo), 0);
    checkOutput("high thr almost_empty", int'(almost_empty_fifo), 1);
    checkOutput("high thr full", int'(full_fifo), 1);
    umbral_lleno = CW'(3);
    umbral_vacio = CW'(1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, '0, 0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, DW'(10'h0A1 + i), 0);
    checkOutput("pre-reset count", int'(count), 3);
    wr_enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset count", int'(count), 0);
    checkOutput("async reset empty", int'(empty_fifo), 1);
    checkOutput("async reset full", int'(full_fifo), 0);
    checkOutput("async reset almost_empty", int'(almost_empty_fifo), 1);
    checkOutput("async reset almost_full", int'(almost_full_fifo), 0);
    checkOutput("async reset data", int'(data_out), 0);
    checkOutput("async reset valid", int'(valid_out), 0);
    checkOutput("async reset error", int'(error), 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 1, '0, 0);
    checkOutput("post-reset underflow error", int'(error), 1);
    checkOutput("post-reset valid", int'(valid_out), 0);
    applyStimulus(0, 0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
